// File: rtl/sdram_test_pkg.sv
// Shared constants and helpers for the SDRAM retention tester:
// ASCII codes for the dump lines, fail-log entry layout, baud divider math.
package sdram_test_pkg;

    localparam logic [7:0] CR    = 8'h0D;
    localparam logic [7:0] LF    = 8'h0A;
    localparam logic [7:0] TAG_F = 8'h46;  // 'F' : fail entry
    localparam logic [7:0] TAG_T = 8'h54;  // 'T' : trial marker
    localparam logic [7:0] TAG_D = 8'h44;  // 'D' : anything else

    localparam int         FAIL_BIT    = 15;
    localparam logic [7:0] MARKER_BYTE = 8'hFF;
    localparam int         LINE_LEN    = 7;  // tag + 4 hex + CR + LF

    typedef logic [7:0] char_t;

    // Upper-case ASCII hex digit for one nibble.
    function automatic char_t hex2ascii(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    // Clocks per UART bit, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter. Each bit is held exactly DIV clocks. tx_done fires
// during the last clock of the stop bit, and a tx_start in that same cycle
// is accepted so consecutive frames run back-to-back with no idle gap.
module uart_tx_8n1 #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       txd
);

    localparam int CNT_W = $clog2(DIV + 1);

    logic [CNT_W-1:0] div_cnt_reg;
    logic [3:0]       bit_cnt_reg;   // 0 = start, 1..8 = data, 9 = stop
    logic [8:0]       shift_reg;     // remaining data bits with stop bit on top
    logic             busy_reg;
    logic             txd_reg;
    logic             bit_end;

    assign bit_end = (div_cnt_reg == CNT_W'(DIV - 1));
    assign tx_done = busy_reg && bit_end && (bit_cnt_reg == 4'd9);
    assign tx_busy = busy_reg && !tx_done;
    assign txd     = txd_reg;

    // Frame sequencer: load on start, shift one bit every DIV clocks, line idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '1;
            busy_reg    <= 1'b0;
            txd_reg     <= 1'b1;
        end else if (tx_start && !tx_busy) begin
            busy_reg    <= 1'b1;
            txd_reg     <= 1'b0;
            shift_reg   <= {1'b1, tx_data};
            bit_cnt_reg <= '0;
            div_cnt_reg <= '0;
        end else if (busy_reg) begin
            if (bit_end) begin
                div_cnt_reg <= '0;
                if (bit_cnt_reg == 4'd9) begin
                    busy_reg <= 1'b0;
                end else begin
                    txd_reg     <= shift_reg[0];
                    shift_reg   <= {1'b1, shift_reg[8:1]};
                    bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fail_log_uart_dump.sv
// Fail-log dumper: walks the fail-log RAM from BASE_ADDR for log_len entries
// and sends each as "<tag><4 hex>\r\n" over UART. Bytes within a line are
// chained on tx_done so the serial stream has no gaps inside a line.
module fail_log_uart_dump
    import sdram_test_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 16,
    parameter int BASE_ADDR = 1,
    parameter int RD_LAT    = 1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] log_len,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rden,
    input  logic [DATA_W-1:0] ram_q,
    output logic              uart_txd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] words_sent
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int LAT_W = $clog2(RD_LAT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD_REQ = 3'd1;
    localparam logic [2:0] S_RD_WAIT= 3'd2;
    localparam logic [2:0] S_FMT    = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;
    localparam logic [2:0] S_TXWAIT = 3'd5;
    localparam logic [2:0] S_NEXT   = 3'd6;
    localparam logic [2:0] S_FIN    = 3'd7;

    logic [2:0]        state_reg;
    logic [ADDR_W-1:0] len_reg;
    logic [ADDR_W-1:0] ptr_reg;
    logic [ADDR_W-1:0] words_reg;
    logic [LAT_W-1:0]  lat_cnt_reg;
    logic [DATA_W-1:0] word_reg;
    logic [7:0][7:0]   line_reg;     // element 7 is padding
    logic [2:0]        idx_reg;      // byte of the line currently on the wire
    logic              abort_pend_reg;

    logic              abort_seen;
    logic              tx_start;
    logic              tx_chain;
    logic [2:0]        tx_sel;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_done;
    char_t             tag_char;
    char_t             hex_char [4];

    assign abort_seen = abort_pend_reg || abort;
    assign ram_addr   = ptr_reg;
    assign ram_rden   = (state_reg == S_RD_REQ);
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_FIN);
    assign done       = (state_reg == S_FIN);
    assign words_sent = words_reg;

    // Hand the next byte of the line to the UART in the same cycle the current one ends.
    assign tx_chain = (state_reg == S_TXWAIT) && tx_done &&
                      (idx_reg != 3'(LINE_LEN - 1)) && !abort_seen;
    assign tx_start = ((state_reg == S_SEND) && !tx_busy && !abort_seen) || tx_chain;
    assign tx_sel   = tx_chain ? (idx_reg + 3'd1) : idx_reg;
    assign tx_data  = line_reg[tx_sel];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hex
            assign hex_char[gi] = hex2ascii(word_reg[15 - 4*gi -: 4]);
        end
    endgenerate

    // Entry classification: fail bit first, then trial marker, else plain data.
    always_comb begin
        tag_char = TAG_D;
        if (word_reg[FAIL_BIT])
            tag_char = TAG_F;
        else if (word_reg[7:0] == MARKER_BYTE)
            tag_char = TAG_T;
    end

    // Abort is remembered while busy so it acts at the next byte boundary.
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n)
            abort_pend_reg <= 1'b0;
        else if (state_reg == S_IDLE)
            abort_pend_reg <= 1'b0;
        else if (abort)
            abort_pend_reg <= 1'b1;
    end

    // Dump sequencer: read entry, format line, transmit 7 bytes, advance pointer.
    always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg   <= S_IDLE;
            len_reg     <= '0;
            ptr_reg     <= '0;
            words_reg   <= '0;
            lat_cnt_reg <= '0;
            word_reg    <= '0;
            line_reg    <= '0;
            idx_reg     <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        len_reg   <= log_len;
                        ptr_reg   <= ADDR_W'(BASE_ADDR);
                        words_reg <= '0;
                        state_reg <= (log_len == '0) ? S_FIN : S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    lat_cnt_reg <= '0;
                    state_reg   <= abort_seen ? S_IDLE : S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (abort_seen) begin
                        state_reg <= S_IDLE;
                    end else if (lat_cnt_reg == LAT_W'(RD_LAT - 1)) begin
                        word_reg  <= ram_q;
                        state_reg <= S_FMT;
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg + LAT_W'(1);
                    end
                end
                S_FMT: begin
                    line_reg  <= {8'h00, LF, CR, hex_char[3], hex_char[2],
                                  hex_char[1], hex_char[0], tag_char};
                    idx_reg   <= '0;
                    state_reg <= abort_seen ? S_IDLE : S_SEND;
                end
                S_SEND: begin
                    if (abort_seen)
                        state_reg <= S_IDLE;
                    else if (!tx_busy)
                        state_reg <= S_TXWAIT;
                end
                S_TXWAIT: begin
                    if (tx_done) begin
                        if (idx_reg == 3'(LINE_LEN - 1))
                            state_reg <= S_NEXT;
                        else if (abort_seen)
                            state_reg <= S_IDLE;
                        else
                            idx_reg <= idx_reg + 3'd1;
                    end
                end
                S_NEXT: begin
                    words_reg <= words_reg + ADDR_W'(1);
                    ptr_reg   <= ptr_reg + ADDR_W'(1);
                    len_reg   <= len_reg - ADDR_W'(1);
                    if (len_reg == ADDR_W'(1))
                        state_reg <= S_FIN;
                    else if (abort_seen)
                        state_reg <= S_IDLE;
                    else
                        state_reg <= S_RD_REQ;
                end
                S_FIN: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    uart_tx_8n1 #(
        .DIV (DIV)
    ) u_tx (
        .clk      (CLOCK_50),
        .rst_n    (RESET_n),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .txd      (uart_txd)
    );

endmodule

// File: tb/tb_fail_log_uart_dump.sv
// Directed bench for fail_log_uart_dump: a fast-baud instance for line content,
// a second instance with BASE_ADDR at the top of the RAM for wrap/reset, and a
// standalone 434-clock transmitter for exact bit timing.
`timescale 1ns/1ps
module tb_fail_log_uart_dump;

    localparam int ADDR_W  = 14;
    localparam int DATA_W  = 16;
    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD_F  = 2_500_000;   // 20 clocks per bit
    localparam int DIV_F   = 20;
    localparam int BIT_DIV = 434;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    // main instance
    logic              start = 1'b0, abort = 1'b0;
    logic [ADDR_W-1:0] log_len = '0;
    logic [ADDR_W-1:0] ram_addr, words_sent;
    logic              ram_rden, uart_txd, busy, done;
    logic [DATA_W-1:0] ram_q;
    // wrap instance
    logic              start_w = 1'b0, abort_w = 1'b0;
    logic [ADDR_W-1:0] ram_addr_w, words_sent_w;
    logic              ram_rden_w, uart_txd_w, busy_w, done_w;
    logic [DATA_W-1:0] ram_q_w;
    // bare transmitter
    logic              bit_start = 1'b0;
    logic [7:0]        bit_data = 8'h00;
    logic              bit_busy, bit_done, bit_txd;

    logic [15:0]       mem [0:16383];
    int                vec_cnt = 0, err_cnt = 0;
    int                done_cnt = 0, done_w_cnt = 0, frame_err = 0;
    logic [ADDR_W-1:0] rd_log [$];
    logic [ADDR_W-1:0] rd_log_w [$];
    logic [7:0]        rx_q [$];
    logic [7:0]        exp_b [$];
    logic [7:0]        rx_byte;
    logic              mon_sel = 1'b0;
    logic              mon_txd;

    fail_log_uart_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD_F), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .BASE_ADDR(1), .RD_LAT(1)) dut (
        .CLOCK_50(clk), .RESET_n(rst_n), .start(start), .abort(abort), .log_len(log_len),
        .ram_addr(ram_addr), .ram_rden(ram_rden), .ram_q(ram_q), .uart_txd(uart_txd),
        .busy(busy), .done(done), .words_sent(words_sent));

    fail_log_uart_dump #(.CLK_HZ(CLK_HZ), .BAUD(BAUD_F), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                         .BASE_ADDR(16383), .RD_LAT(1)) dut_w (
        .CLOCK_50(clk), .RESET_n(rst_n), .start(start_w), .abort(abort_w), .log_len(log_len),
        .ram_addr(ram_addr_w), .ram_rden(ram_rden_w), .ram_q(ram_q_w), .uart_txd(uart_txd_w),
        .busy(busy_w), .done(done_w), .words_sent(words_sent_w));

    uart_tx_8n1 #(.DIV(BIT_DIV)) u_bit (
        .clk(clk), .rst_n(rst_n), .tx_start(bit_start), .tx_data(bit_data),
        .tx_busy(bit_busy), .tx_done(bit_done), .txd(bit_txd));

    // RAM model, one clock read latency
    always @(posedge clk) begin
        if (ram_rden)   ram_q   <= mem[ram_addr];
        if (ram_rden_w) ram_q_w <= mem[ram_addr_w];
    end

    // event monitors
    always @(negedge clk) begin
        if (done === 1'b1)   done_cnt   <= done_cnt + 1;
        if (done_w === 1'b1) done_w_cnt <= done_w_cnt + 1;
        if (ram_rden === 1'b1)   rd_log.push_back(ram_addr);
        if (ram_rden_w === 1'b1) rd_log_w.push_back(ram_addr_w);
    end

    // UART receiver, samples mid-bit
    assign mon_txd = mon_sel ? uart_txd_w : uart_txd;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_txd === 1'b0) begin
                repeat (DIV_F/2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV_F) @(negedge clk);
                    rx_byte[i] = mon_txd;
                end
                repeat (DIV_F) @(negedge clk);
                if (mon_txd !== 1'b1) frame_err++;
                rx_q.push_back(rx_byte);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bytes(input string tag);
        logic [7:0] obs;
        chk({tag, "_count"}, rx_q.size(), exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            obs = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            chk($sformatf("%s_byte%0d", tag, i), {24'h0, obs}, {24'h0, exp_b[i]});
        end
    endtask

    task automatic pulse_start;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (bit_txd === lvl && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, n, d0, rb;
        logic [7:0] pat;

        // ---------------- reset state
        repeat (3) @(negedge clk);
        chk("rst_txd", uart_txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rden", ram_rden, 1'b0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_words", words_sent, 0);
        chk("rst_bit_txd", bit_txd, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ---------------- 1: single fail entry, whole-line timing
        mem[1] = 16'h8ABC; log_len = 1; d0 = done_cnt; rx_q.delete();
        pulse_start();
        wait_done(5000, cyc);
        chk("t1_done", done, 1'b1);
        vec_cnt++;
        assert (cyc >= 70*DIV_F && cyc <= 70*DIV_F + 10) else begin
            err_cnt++;
            $error("FAIL t1_line_time: observed %0d expected %0d..%0d", cyc, 70*DIV_F, 70*DIV_F + 10);
        end
        @(negedge clk);
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_busy", busy, 1'b0);
        chk("t1_words", words_sent, 1);
        chk("t1_txd_idle", uart_txd, 1'b1);
        exp_b = '{8'h46, 8'h38, 8'h41, 8'h42, 8'h43, 8'h0D, 8'h0A};
        chk_bytes("t1");

        // ---------------- 2: marker + data, abort in idle, start wins over abort
        mem[1] = 16'h03FF; mem[2] = 16'h1234; log_len = 2; rx_q.delete();
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t2_idle_abort", busy, 1'b0);
        d0 = done_cnt; rb = rd_log.size();
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        chk("t2_start_wins", busy, 1'b1);
        wait_done(6000, cyc);
        chk("t2_done", done, 1'b1);
        @(negedge clk);
        chk("t2_done_once", done_cnt - d0, 1);
        chk("t2_words", words_sent, 2);
        chk("t2_reads", rd_log.size() - rb, 2);
        chk("t2_addr0", (rd_log.size() > rb) ? rd_log[rb] : 'x, 1);
        chk("t2_addr1", (rd_log.size() > rb + 1) ? rd_log[rb + 1] : 'x, 2);
        exp_b = '{8'h54, 8'h30, 8'h33, 8'h46, 8'h46, 8'h0D, 8'h0A,
                  8'h44, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A};
        chk_bytes("t2");

        // ---------------- 3: zero-length dump
        begin
            int busy_n, done_at, low_n;
            busy_n = 0; done_at = 0; low_n = 0;
            log_len = 0; d0 = done_cnt;
            @(negedge clk); start = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                start = 1'b0;
                if (busy === 1'b1) busy_n++;
                if (done === 1'b1 && done_at == 0) done_at = k;
                if (uart_txd !== 1'b1) low_n++;
            end
            chk("t3_done_within_3", (done_at >= 1 && done_at <= 3), 1'b1);
            chk("t3_busy_le_2", (busy_n <= 2), 1'b1);
            chk("t3_txd_high", low_n, 0);
            chk("t3_done_once", done_cnt - d0, 1);
            chk("t3_words", words_sent, 0);
        end

        // ---------------- 4: 0x55 bit timing at 434 clocks per bit
        pat = 8'h55;
        @(negedge clk); bit_data = pat; bit_start = 1'b1;
        @(negedge clk); bit_start = 1'b0;
        chk("t4_busy", bit_busy, 1'b1);
        chk("t4_start_lvl", bit_txd, 1'b0);
        run_len(1'b0, n);
        chk("t4_start_len", n, BIT_DIV);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t4_bit%0d_lvl", i), bit_txd, pat[i]);
            run_len(pat[i], n);
            chk($sformatf("t4_bit%0d_len", i), n, BIT_DIV);
        end
        chk("t4_stop_lvl", bit_txd, 1'b1);
        n = 1;
        while (bit_done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
            if (bit_txd !== 1'b1) n = 1000;
        end
        chk("t4_stop_len", n, BIT_DIV);
        @(negedge clk);
        chk("t4_idle_txd", bit_txd, 1'b1);
        chk("t4_idle_busy", bit_busy, 1'b0);

        // ---------------- 5: start ignored while busy, abort mid-line
        mem[1] = 16'h0001; mem[2] = 16'h8000; mem[3] = 16'h00FF;
        log_len = 3; d0 = done_cnt; rx_q.delete();
        pulse_start();
        cyc = 0;
        while (rx_q.size() < 8 && cyc < 4000) begin @(negedge clk); cyc++; end
        chk("t5_line1_out", rx_q.size(), 8);
        @(negedge clk); start = 1'b1; log_len = 5;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("t5_start_ignored_words", words_sent, 1);
        chk("t5_still_busy", busy, 1'b1);
        cyc = 0;
        while (rx_q.size() < 9 && cyc < 400) begin @(negedge clk); cyc++; end
        repeat (30) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("t5_busy_after_abort", busy, 1'b1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        chk("t5_busy_fell", busy, 1'b0);
        chk("t5_bytes_at_fall", rx_q.size(), 10);
        repeat (300) @(negedge clk);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_words", words_sent, 1);
        chk("t5_txd_idle", uart_txd, 1'b1);
        exp_b = '{8'h44, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A,
                  8'h46, 8'h38, 8'h30};
        chk_bytes("t5");

        // ---------------- 6: address wrap, reset mid-frame, clean restart
        mem[16383] = 16'h0042; mem[0] = 16'h8001; log_len = 2; rb = rd_log_w.size();
        @(negedge clk); start_w = 1'b1;
        @(negedge clk); start_w = 1'b0;
        cyc = 0;
        while (rd_log_w.size() < rb + 2 && cyc < 4000) begin @(negedge clk); cyc++; end
        chk("t6_reads", rd_log_w.size() - rb, 2);
        chk("t6_addr0", (rd_log_w.size() > rb) ? rd_log_w[rb] : 'x, 16383);
        chk("t6_addr1", (rd_log_w.size() > rb + 1) ? rd_log_w[rb + 1] : 'x, 0);
        cyc = 0;
        while (uart_txd_w !== 1'b0 && cyc < 500) begin @(negedge clk); cyc++; end
        chk("t6_midframe_low", uart_txd_w, 1'b0);
        chk("t6_midframe_busy", busy_w, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_txd", uart_txd_w, 1'b1);
        chk("t6_rst_busy", busy_w, 1'b0);
        chk("t6_rst_words", words_sent_w, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        mon_sel = 1'b1; rx_q.delete();
        log_len = 1; d0 = done_w_cnt; rb = rd_log_w.size();
        @(negedge clk); start_w = 1'b1;
        @(negedge clk); start_w = 1'b0;
        cyc = 0;
        while (done_w !== 1'b1 && cyc < 5000) begin @(negedge clk); cyc++; end
        chk("t6_restart_done", done_w, 1'b1);
        @(negedge clk);
        chk("t6_restart_done_once", done_w_cnt - d0, 1);
        chk("t6_restart_words", words_sent_w, 1);
        chk("t6_restart_addr", (rd_log_w.size() > rb) ? rd_log_w[rb] : 'x, 16383);
        exp_b = '{8'h44, 8'h30, 8'h30, 8'h34, 8'h32, 8'h0D, 8'h0A};
        chk_bytes("t6");
        chk("framing", frame_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
